// File: rtl/distributed_fifo_m.sv
// distributed_fifo_m
// Single-clock FIFO on inferred distributed RAM with valid/ready on both
// sides, a registered fill level and almost_full flag, and an optional
// output register stage (OUT_REGISTERED = "YES" / "NO").
//
// Optional feature macro: DIST_FIFO_FLUSH_EN
//   defined   -> adds the 'flush' input (synchronous clear of all contents)
//   undefined -> no flush port, flush term tied off
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. valid never waits on ready. in_ready is
// derived from registered state only (plus flush), so there is no
// combinational path from out_ready to in_ready. out_valid/out_data hold
// steady until the word is taken.
module distributed_fifo_m #(
  parameter int    ADDR_WIDTH     = 4,
  parameter int    WORD_WIDTH     = 8,
  parameter string OUT_REGISTERED = "YES",
  parameter int    AFULL_THRESH   = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DIST_FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full
);

  localparam bit                  OUT_REG   = (OUT_REGISTERED == "YES");
  localparam int                  DEPTH_N   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

  // Storage and pointers. ram_cnt is one bit wider than the pointers so a
  // full RAM (wr_ptr == rd_ptr, cnt == DEPTH) is distinct from empty.
  logic [WORD_WIDTH-1:0] ram [DEPTH_N];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [ADDR_WIDTH:0]   ram_cnt_nxt;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic [WORD_WIDTH-1:0] ram_head;

  logic flush_c;  // synchronous clear request (constant 0 without the feature)
  logic push;     // word written into RAM this cycle
  logic pop;      // consumer takes the head word this cycle
  logic ram_rd;   // word leaves the RAM (rd_ptr advances) this cycle
  logic ov_q;     // output register occupancy (0 when unregistered)
  logic ov_nxt;

`ifdef DIST_FIFO_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // A flush empties everything on the coming edge, so the writer is never
  // back-pressured while it is asserted; any push it offers is discarded.
  assign in_ready = (ram_cnt < DEPTH) | flush_c;
  assign push     = in_valid & in_ready & ~flush_c;
  assign ram_head = ram[rd_ptr];

  generate
    if (OUT_REG) begin : g_out_reg
      logic [WORD_WIDTH-1:0] dout_q;

      // The output register refills whenever it is empty or being emptied
      // and the RAM has a word, giving one word per cycle when streaming.
      assign ram_rd    = (ram_cnt != '0) & (~ov_q | out_ready);
      assign pop       = ov_q & out_ready;
      assign ov_nxt    = flush_c ? 1'b0 : (ram_rd | (ov_q & ~pop));
      assign out_valid = ov_q;
      assign out_data  = dout_q;

      // Output stage: occupancy flag and head word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q   <= 1'b0;
          dout_q <= '0;
        end else begin
          ov_q <= ov_nxt;
          if (ram_rd && !flush_c) begin
            dout_q <= ram_head;
          end
        end
      end
    end else begin : g_out_comb
      // Head word is read straight from RAM; popping it is the RAM read.
      assign out_valid = (ram_cnt != '0);
      assign out_data  = ram_head;
      assign pop       = out_valid & out_ready;
      assign ram_rd    = pop;
      assign ov_q      = 1'b0;
      assign ov_nxt    = 1'b0;
    end
  endgenerate

  // Next RAM occupancy; a push and a RAM read in one cycle cancel out.
  always_comb begin
    ram_cnt_nxt = ram_cnt;
    if (flush_c) begin
      ram_cnt_nxt = '0;
    end else begin
      ram_cnt_nxt = ram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(ram_rd);
    end
  end

  // Total words held, counting the output register when present.
  always_comb begin
    level_nxt = ram_cnt_nxt + (ADDR_WIDTH+1)'(ov_nxt);
  end

  // Pointer, occupancy, level and almost_full registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (flush_c) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        end
        if (ram_rd) begin
          rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        end
      end
      ram_cnt     <= ram_cnt_nxt;
      level       <= level_nxt;
      almost_full <= (level_nxt >= AFULL_LVL);
    end
  end

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ram[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_distributed_fifo_m.sv
// Testbench for distributed_fifo_m: one unregistered ("NO") and one
// registered ("YES") instance, ADDR_WIDTH=3, WORD_WIDTH=8, AFULL_THRESH=6.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_distributed_fifo_m;

  localparam int AW = 3;
  localparam int W  = 8;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // "NO" instance signals
  logic          n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_afull;
  logic [W-1:0]  n_in_data, n_out_data;
  logic [AW:0]   n_level;
  // "YES" instance signals
  logic          y_in_valid, y_in_ready, y_out_valid, y_out_ready, y_afull;
  logic [W-1:0]  y_in_data, y_out_data;
  logic [AW:0]   y_level;
`ifdef DIST_FIFO_FLUSH_EN
  logic          n_flush, y_flush;
`endif

  distributed_fifo_m #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(W), .OUT_REGISTERED("NO"), .AFULL_THRESH(6)
  ) dut_no (
    .clk(clk), .rst_n(rst_n),
`ifdef DIST_FIFO_FLUSH_EN
    .flush(n_flush),
`endif
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .level(n_level), .almost_full(n_afull)
  );

  distributed_fifo_m #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(W), .OUT_REGISTERED("YES"), .AFULL_THRESH(6)
  ) dut_yes (
    .clk(clk), .rst_n(rst_n),
`ifdef DIST_FIFO_FLUSH_EN
    .flush(y_flush),
`endif
    .in_valid(y_in_valid), .in_ready(y_in_ready), .in_data(y_in_data),
    .out_valid(y_out_valid), .out_ready(y_out_ready), .out_data(y_out_data),
    .level(y_level), .almost_full(y_afull)
  );

  // Scoreboard
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks (called on a falling edge, return on the next one)
  task automatic push_no(input logic [W-1:0] d);
    n_in_valid = 1'b1;
    n_in_data  = d;
    if (n_in_ready) exp_q.push_back(d);
    @(negedge clk);
    n_in_valid = 1'b0;
  endtask

  task automatic push_yes(input logic [W-1:0] d);
    y_in_valid = 1'b1;
    y_in_data  = d;
    if (y_in_ready) exp_q.push_back(d);
    @(negedge clk);
    y_in_valid = 1'b0;
  endtask

  task automatic drain_no(input string tag);
    n_out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (n_out_valid) check(tag, n_out_data, exp_q.pop_front());
      @(negedge clk);
    end
    n_out_ready = 1'b0;
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_lvl"}, n_level, 0);
    check({tag, "_ov"}, n_out_valid, 0);
  endtask

  task automatic drain_yes(input string tag);
    y_out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (y_out_valid) check(tag, y_out_data, exp_q.pop_front());
      @(negedge clk);
    end
    y_out_ready = 1'b0;
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_lvl"}, y_level, 0);
    check({tag, "_ov"}, y_out_valid, 0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    logic [W-1:0] d;
    n_in_valid = 0; n_in_data = '0; n_out_ready = 0;
    y_in_valid = 0; y_in_data = '0; y_out_ready = 0;
`ifdef DIST_FIFO_FLUSH_EN
    n_flush = 0; y_flush = 0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_no_rdy", n_in_ready, 1);
    check("rst_no_ov", n_out_valid, 0);
    check("rst_no_lvl", n_level, 0);
    check("rst_no_af", n_afull, 0);
    check("rst_y_rdy", y_in_ready, 1);
    check("rst_y_ov", y_out_valid, 0);
    check("rst_y_lvl", y_level, 0);
    check("rst_y_af", y_afull, 0);
    check("rst_y_data", y_out_data, 0);

    // "NO" fill 0x01..0x08, consumer stalled
    for (int i = 1; i <= 8; i++) begin
      check("no_fill_lvl", n_level, i - 1);
      check("no_fill_af", n_afull, (i - 1) >= 6);
      check("no_fill_rdy", n_in_ready, 1);
      d = 8'(i);
      push_no(d);
    end
    check("no_full_lvl", n_level, 8);
    check("no_full_rdy", n_in_ready, 0);
    check("no_full_af", n_afull, 1);
    check("no_full_ov", n_out_valid, 1);
    exp_q.delete();
    // drain in order
    n_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("no_drain_data", n_out_data, i);
      check("no_drain_lvl", n_level, 9 - i);
      check("no_drain_ov", n_out_valid, 1);
      @(negedge clk);
    end
    n_out_ready = 1'b0;
    check("no_empty_lvl", n_level, 0);
    check("no_empty_ov", n_out_valid, 0);
    check("no_empty_af", n_afull, 0);

    // "NO" full plus pop: pop accepted, push refused, push lands next cycle
    for (int i = 1; i <= 8; i++) begin
      d = 8'(8'h30 + i);
      push_no(d);
    end
    check("fp_lvl8", n_level, 8);
    check("fp_rdy0", n_in_ready, 0);
    n_in_valid = 1'b1; n_in_data = 8'h39; n_out_ready = 1'b1;
    check("fp_head", n_out_data, 8'h31);
    void'(exp_q.pop_front());
    @(negedge clk);
    check("fp_lvl7", n_level, 7);
    check("fp_rdy1", n_in_ready, 1);
    check("fp_next", n_out_data, 8'h32);
    n_out_ready = 1'b0;
    exp_q.push_back(8'h39);
    @(negedge clk);
    n_in_valid = 1'b0;
    check("fp_relvl8", n_level, 8);
    check("fp_rerdy0", n_in_ready, 0);
    drain_no("fp_drain");

    // "YES" fill: latency 2, capacity 9
    y_in_valid = 1'b1; y_in_data = 8'h11; exp_q.push_back(8'h11);
    @(negedge clk);
    check("y_lat1_ov", y_out_valid, 0);
    check("y_lat1_lvl", y_level, 1);
    y_in_data = 8'h12; exp_q.push_back(8'h12);
    @(negedge clk);
    check("y_lat2_ov", y_out_valid, 1);
    check("y_lat2_data", y_out_data, 8'h11);
    check("y_lat2_lvl", y_level, 2);
    y_in_valid = 1'b0;
    for (int i = 3; i <= 9; i++) begin
      check("y_fill_lvl", y_level, i - 1);
      check("y_fill_rdy", y_in_ready, 1);
      d = 8'(8'h10 + i);
      push_yes(d);
    end
    check("y_full_lvl", y_level, 9);
    check("y_full_rdy", y_in_ready, 0);
    check("y_full_af", y_afull, 1);
    y_in_valid = 1'b1; y_in_data = 8'hEE;
    @(negedge clk);
    y_in_valid = 1'b0;
    check("y_full_refuse", y_level, 9);
    drain_yes("y_drain");

    // "YES" streaming at level 4 across pointer wraps
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h40 + i);
      push_yes(d);
    end
    check("st_pre_lvl", y_level, 4);
    y_out_ready = 1'b1;
    y_in_valid  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      y_in_data = 8'(8'h50 + c);
      if (y_in_ready) exp_q.push_back(y_in_data);
      if (y_out_valid) check("st_data", y_out_data, exp_q.pop_front());
      check("st_lvl", y_level, 4);
      @(negedge clk);
    end
    y_in_valid = 1'b0;
    drain_yes("st_drain");

    // Asynchronous reset mid-operation with 3 words buffered
    for (int i = 0; i < 3; i++) begin
      d = 8'(8'h70 + i);
      push_no(d);
      push_yes(d);
    end
    check("mr_pre_lvl", n_level, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mr_no_ov", n_out_valid, 0);
    check("mr_no_lvl", n_level, 0);
    check("mr_no_rdy", n_in_ready, 1);
    check("mr_y_ov", y_out_valid, 0);
    check("mr_y_lvl", y_level, 0);
    check("mr_y_data", y_out_data, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mr_post_no_ov", n_out_valid, 0);
    check("mr_post_y_ov", y_out_valid, 0);
    check("mr_post_y_lvl", y_level, 0);

`ifdef DIST_FIFO_FLUSH_EN
    // Flush at level 5 with simultaneous push and pop
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h61 + i);
      push_no(d);
    end
    check("fl_pre_lvl", n_level, 5);
    n_flush = 1'b1; n_in_valid = 1'b1; n_in_data = 8'h77; n_out_ready = 1'b1;
    check("fl_rdy", n_in_ready, 1);
    @(negedge clk);
    n_flush = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0;
    check("fl_lvl", n_level, 0);
    check("fl_ov", n_out_valid, 0);
    exp_q.delete();
    push_no(8'hAA);
    check("fl_next_ov", n_out_valid, 1);
    check("fl_next_data", n_out_data, 8'hAA);
    drain_no("fl_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
